// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed NDIG-digit common-anode 7-segment driver with shadow buffering, blanking and cursor blink
module seg7_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK = 500,
  parameter int BLINK_FR = 64,
  parameter int LZB = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [3:0]        STATE,
  input  logic [4*NDIG-1:0] QUE,
  input  logic [4*NDIG-1:0] DIN,
  input  logic [2:0]        CUR,
  input  logic              LOAD,
  output logic [6:0]        nHEX,
  output logic [NDIG-1:0]   nDIG
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int FW = BLINK_FR > 1 ? $clog2(BLINK_FR) : 1;
  localparam logic [PW-1:0] PC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_V = PW'(BLANK);
  localparam logic [DW-1:0] DI_MAX = DW'(NDIG - 1);
  localparam logic [FW-1:0] FC_MAX = FW'(BLINK_FR - 1);
  logic [PW-1:0] pc;
  logic [DW-1:0] di;
  logic [FW-1:0] fc;
  logic bp;
  logic [4*NDIG-1:0] que_sh, din_sh, que_e, din_e;
  logic [2:0] cur_sh, cur_e;
  logic pc_wrap, di_wrap, fc_wrap;
  logic [NDIG-1:0] lz;
  logic run, blink;
  logic [3:0] qn, dn;
  logic [6:0] code, hex_d;
  logic [NDIG-1:0] dig_d;

  function automatic logic [6:0] bcd(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1011000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] fac(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return bcd(4'd2);
      4'd2: return bcd(4'd3);
      4'd3: return bcd(4'd5);
      4'd4: return bcd(4'd7);
      4'd5: return bcd(4'd1);
      default: return 7'b1111111;
    endcase
  endfunction

  assign pc_wrap = pc == PC_MAX;
  assign di_wrap = pc_wrap && di == DI_MAX;
  assign fc_wrap = di_wrap && fc == FC_MAX;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= '0;
      di <= '0;
      fc <= '0;
      bp <= 1'b0;
    end else begin
      pc <= pc_wrap ? '0 : pc + 1'b1;
      if (pc_wrap) di <= di_wrap ? '0 : di + 1'b1;
      if (di_wrap) fc <= fc_wrap ? '0 : fc + 1'b1;
      if (fc_wrap) bp <= ~bp;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      que_sh <= '0;
      din_sh <= '0;
      cur_sh <= '0;
    end else if (LOAD) begin
      que_sh <= QUE;
      din_sh <= DIN;
      cur_sh <= CUR;
    end
  end

  // a LOAD in this cycle already feeds the next registered output
  always_comb begin
    que_e = LOAD ? QUE : que_sh;
    din_e = LOAD ? DIN : din_sh;
    cur_e = LOAD ? CUR : cur_sh;
    qn = que_e[4*di +: 4];
    dn = din_e[4*di +: 4];
    lz = '0;
    run = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run = run && que_e[4*i +: 4] == 4'd0;
      lz[i] = run && i != 0 && LZB != 0;
    end
    blink = bp && {1'b0, cur_e} < 4'(NDIG) && cur_e == 3'(di);
    code = STATE == 4'b0010 ? 7'b0101111 :
           STATE == 4'b0011 ? (lz[di] ? 7'h7F : bcd(qn)) :
           STATE == 4'b0100 ? (blink ? 7'h7F : fac(dn)) : 7'h7F;
    hex_d = pc < BLANK_V ? 7'h7F : code;
    dig_d = pc < BLANK_V ? '1 : ~(NDIG'(1) << di);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      nHEX <= 7'h7F;
      nDIG <= '1;
    end else begin
      nHEX <= hex_d;
      nDIG <= dig_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard and vector-table bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4, SD = 8, BL = 2, BF = 2;
  logic CLK = 0, nRST = 0, LOAD = 0;
  logic [3:0] STATE = 0;
  logic [15:0] QUE = 0, DIN = 0;
  logic [2:0] CUR = 0;
  logic [6:0] nHEX;
  logic [3:0] nDIG;
  int checks = 0, failures = 0;
  int m_pc = 0, m_di = 0, m_fc = 0;
  bit m_bp = 0;
  logic [15:0] m_que = 0, m_din = 0;
  logic [2:0] m_cur = 0;
  logic [10:0] sb[$];
  logic [6:0] seen[4];
  bit on2, off2;

  typedef struct {
    logic [3:0] st;
    logic [15:0] q;
    logic [15:0] d;
    logic [2:0] c;
    logic ld;
    int n;
  } vec_t;
  vec_t tbl[8];

  always #5 CLK = ~CLK;

  seg7_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD), .BLANK(BL), .BLINK_FR(BF), .LZB(1)) dut (
    .CLK(CLK), .nRST(nRST), .STATE(STATE), .QUE(QUE), .DIN(DIN), .CUR(CUR),
    .LOAD(LOAD), .nHEX(nHEX), .nDIG(nDIG)
  );

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1011000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [10:0] model();
    logic [15:0] q, d;
    logic [2:0] c;
    logic [3:0] n, g;
    logic [6:0] h;
    bit lead;
    q = LOAD ? QUE : m_que;
    d = LOAD ? DIN : m_din;
    c = LOAD ? CUR : m_cur;
    if (m_pc < BL) return 11'h7FF;
    g = 4'b0001 << m_di;
    g = ~g;
    h = 7'h7F;
    if (STATE == 4'd2) h = 7'b0101111;
    else if (STATE == 4'd3) begin
      n = q[4*m_di +: 4];
      lead = 1;
      for (int j = m_di; j < 4; j++) if (q[4*j +: 4] != 0) lead = 0;
      h = (lead && m_di != 0) ? 7'h7F : seg(int'(n));
    end else if (STATE == 4'd4) begin
      n = d[4*m_di +: 4];
      case (n)
        0: h = 7'b0111111;
        1: h = seg(2);
        2: h = seg(3);
        3: h = seg(5);
        4: h = seg(7);
        5: h = seg(1);
        default: h = 7'h7F;
      endcase
      if (m_bp && int'(c) == m_di) h = 7'h7F;
    end
    return {h, g};
  endfunction

  task automatic step();
    if (!nRST) begin
      m_pc = 0; m_di = 0; m_fc = 0; m_bp = 0; m_que = 0; m_din = 0; m_cur = 0;
    end else begin
      if (LOAD) begin m_que = QUE; m_din = DIN; m_cur = CUR; end
      if (m_pc == SD - 1) begin
        m_pc = 0;
        if (m_di == NDIG - 1) begin
          m_di = 0;
          if (m_fc == BF - 1) begin m_fc = 0; m_bp = !m_bp; end
          else m_fc++;
        end else m_di++;
      end else m_pc++;
    end
  endtask

  task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc();
    logic [10:0] e;
    logic [3:0] m;
    sb.push_back(nRST ? model() : 11'h7FF);
    step();
    @(posedge CLK);
    @(negedge CLK);
    e = sb.pop_front();
    chk("scan", {nHEX, nDIG}, e);
    for (int d = 0; d < 4; d++) begin
      m = 4'b0001 << d;
      if (nDIG == ~m) begin
        seen[d] = nHEX;
        if (d == 2 && nHEX == 7'b0010010) on2 = 1;
        if (d == 2 && nHEX == 7'h7F) off2 = 1;
      end
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 4; d++) seen[d] = 7'h00;
    on2 = 0;
    off2 = 0;
  endtask

  task automatic frame_chk(input string nm, input logic [6:0] e0, e1, e2, e3);
    chk({nm, "_d0"}, {4'h0, seen[0]}, {4'h0, e0});
    chk({nm, "_d1"}, {4'h0, seen[1]}, {4'h0, e1});
    chk({nm, "_d2"}, {4'h0, seen[2]}, {4'h0, e2});
    chk({nm, "_d3"}, {4'h0, seen[3]}, {4'h0, e3});
  endtask

  initial begin
    logic [3:0] em;
    int k;
    tbl[0] = '{4'd3, 16'h0012, 16'h0000, 3'd0, 1'b1, 40};
    tbl[1] = '{4'd4, 16'h1000, 16'h5043, 3'd1, 1'b1, 70};
    tbl[2] = '{4'd4, 16'h0000, 16'hF6A0, 3'd5, 1'b1, 140};
    tbl[3] = '{4'd3, 16'h9876, 16'h0000, 3'd0, 1'b1, 20};
    tbl[4] = '{4'd3, 16'h8000, 16'h0000, 3'd0, 1'b1, 20};
    tbl[5] = '{4'd0, 16'h1111, 16'h0000, 3'd0, 1'b0, 10};
    tbl[6] = '{4'd2, 16'h0000, 16'h0000, 3'd3, 1'b1, 13};
    tbl[7] = '{4'd3, 16'h0305, 16'h0000, 3'd0, 1'b1, 13};
    clr();
    STATE = 4'd2;
    repeat (3) cyc();
    chk("reset_out", {nHEX, nDIG}, 11'h7FF);
    nRST = 1;
    for (int c = 0; c < 40; c++) begin
      cyc();
      em = 4'b0001 << ((c / 8) % 4);
      chk("ready_scan", {nHEX, nDIG}, (c % 8 < 2) ? 11'h7FF : {7'b0101111, ~em});
    end
    STATE = 4'd3; QUE = 16'h0907; LOAD = 1;
    cyc();
    LOAD = 0;
    clr();
    repeat (32) cyc();
    frame_chk("q0907", 7'b1011000, 7'b1000000, 7'b0010000, 7'h7F);
    QUE = 16'h0000; LOAD = 1;
    cyc();
    LOAD = 0;
    clr();
    repeat (32) cyc();
    frame_chk("q0000", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);
    QUE = 16'h1234;
    clr();
    repeat (64) cyc();
    frame_chk("noload", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);
    STATE = 4'd4; DIN = 16'h4321; CUR = 3'd2; LOAD = 1;
    cyc();
    LOAD = 0;
    clr();
    repeat (130) cyc();
    chk("din_d0", {4'h0, seen[0]}, {4'h0, 7'b0100100});
    chk("din_d1", {4'h0, seen[1]}, {4'h0, 7'b0110000});
    chk("din_d3", {4'h0, seen[3]}, {4'h0, 7'b1011000});
    chk("blink_both", {9'h0, on2, off2}, 11'h003);
    STATE = 4'b1000;
    clr();
    repeat (32) cyc();
    frame_chk("off", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    foreach (tbl[i]) begin
      STATE = tbl[i].st; QUE = tbl[i].q; DIN = tbl[i].d; CUR = tbl[i].c; LOAD = tbl[i].ld;
      cyc();
      LOAD = 0;
      repeat (tbl[i].n - 1) cyc();
    end
    STATE = 4'd3; QUE = 16'h1234; LOAD = 1;
    cyc();
    LOAD = 0;
    k = 0;
    while (!(m_di == 2 && m_pc == 4) && k < 64) begin cyc(); k++; end
    chk("pre_rst_dig", {7'h0, nDIG}, 11'h00B);
    nRST = 0;
    #1;
    chk("async_rst", {nHEX, nDIG}, 11'h7FF);
    cyc();
    nRST = 1;
    repeat (2) cyc();
    cyc();
    chk("post_rst_q", {nHEX, nDIG}, {7'b1000000, 4'b1110});
    STATE = 4'd4;
    cyc();
    chk("post_rst_din", {nHEX, nDIG}, {7'b0111111, 4'b1110});
    repeat (8) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
